// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler that owns an APB-programmed SPI master. It programs
// one byte transfer for each grant and returns the received byte to the winner.
module spi_xfer_sched #(
   parameter int N       = 4,
   parameter int TIMEOUT = 4096,
   parameter int TW      = 13
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   req_cpol,
   input  logic [N-1:0]   req_cpha,
   input  logic [4*N-1:0] req_cs,
   input  logic [8*N-1:0] req_div,
   input  logic [8*N-1:0] req_tx,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   done,
   output logic [7:0]     rx_byte,
   output logic           err,
   output logic           psel,
   output logic           penable,
   output logic           pwrite,
   output logic [7:0]     paddr,
   output logic [31:0]    pwdata,
   input  logic [31:0]    prdata,
   input  logic           pready,
   input  logic           spi_irq
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [7:0] ADDR_CTRL = 8'h00;
   localparam logic [7:0] ADDR_DATA = 8'h08;
   localparam logic [7:0] ADDR_DIV  = 8'h0C;
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ARB,
      S_DIV_SET, S_DIV_ACC, S_DATA_SET, S_DATA_ACC, S_CTRL_SET, S_CTRL_ACC,
      S_WAIT_IRQ, S_RD_SET, S_RD_ACC, S_CAPT, S_RESP
   } state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   rr, rr_nx, idx, arb_idx;
   logic            arb_hit;
   int              cand;
   logic            l_cpol, l_cpha, timed_out;
   logic [3:0]      l_cs;
   logic [7:0]      l_div, l_tx, rx_q;
   logic [TW-1:0]   tcnt;
   logic            unused_prdata;

   assign unused_prdata = ^prdata[31:8];
   assign rx_byte       = rx_q;

   // First set request at or after the rr pointer, wrapping N-1 -> 0.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(rr) + k) % N;
         if (!arb_hit && req[IW'(cand)]) begin
            arb_hit = 1'b1;
            arb_idx = IW'(cand);
         end
      end
   end

   assign rr_nx = (arb_idx == IW'(N - 1)) ? '0 : arb_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr        <= '0;
         idx       <= '0;
         l_cpol    <= 1'b0;
         l_cpha    <= 1'b0;
         l_cs      <= '0;
         l_div     <= '0;
         l_tx      <= '0;
         tcnt      <= '0;
         timed_out <= 1'b0;
         rx_q      <= '0;
      end else begin
         if (state == S_ARB && arb_hit) begin
            idx       <= arb_idx;
            rr        <= rr_nx;
            l_cpol    <= req_cpol[arb_idx];
            l_cpha    <= req_cpha[arb_idx];
            l_cs      <= req_cs[{arb_idx, 2'b00} +: 4];
            l_div     <= req_div[{arb_idx, 3'b000} +: 8];
            l_tx      <= req_tx[{arb_idx, 3'b000} +: 8];
            timed_out <= 1'b0;
         end
         tcnt <= (state == S_WAIT_IRQ) ? tcnt + 1'b1 : '0;
         if (state == S_WAIT_IRQ && !spi_irq && tcnt == TCNT_LAST) begin
            timed_out <= 1'b1;
            rx_q      <= '0;
         end
         if (state == S_CAPT) rx_q <= prdata[7:0];
      end
   end

   // APB: setup (psel, !penable) always lasts one cycle; the access phase
   // holds address/data steady until pready, then the next state takes over.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (|req) state_nx = S_ARB;
         S_ARB:      state_nx = arb_hit ? S_DIV_SET : S_IDLE;
         S_DIV_SET:  state_nx = S_DIV_ACC;
         S_DIV_ACC:  if (pready) state_nx = S_DATA_SET;
         S_DATA_SET: state_nx = S_DATA_ACC;
         S_DATA_ACC: if (pready) state_nx = S_CTRL_SET;
         S_CTRL_SET: state_nx = S_CTRL_ACC;
         S_CTRL_ACC: if (pready) state_nx = S_WAIT_IRQ;
         S_WAIT_IRQ: begin
            if (spi_irq)                 state_nx = S_RD_SET;
            else if (tcnt == TCNT_LAST)  state_nx = S_RESP;
         end
         S_RD_SET:   state_nx = S_RD_ACC;
         S_RD_ACC:   if (pready) state_nx = S_CAPT;
         S_CAPT:     state_nx = S_RESP;
         S_RESP:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      gnt     = '0;
      done    = '0;
      err     = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      case (state)
         S_IDLE:  ;
         S_ARB:   if (arb_hit) gnt[arb_idx] = 1'b1;
         default: gnt[idx] = 1'b1;
      endcase
      if (state == S_RESP) begin
         done[idx] = 1'b1;
         err       = timed_out;
      end
      case (state)
         S_DIV_SET, S_DIV_ACC: begin
            psel    = 1'b1;
            penable = (state == S_DIV_ACC);
            pwrite  = 1'b1;
            paddr   = ADDR_DIV;
            pwdata  = {24'h0, l_div};
         end
         S_DATA_SET, S_DATA_ACC: begin
            psel    = 1'b1;
            penable = (state == S_DATA_ACC);
            pwrite  = 1'b1;
            paddr   = ADDR_DATA;
            pwdata  = {24'h0, l_tx};
         end
         S_CTRL_SET, S_CTRL_ACC: begin
            psel    = 1'b1;
            penable = (state == S_CTRL_ACC);
            pwrite  = 1'b1;
            paddr   = ADDR_CTRL;
            pwdata  = {24'h0, l_cs, 1'b0, l_cpha, l_cpol, 1'b1};
         end
         S_RD_SET, S_RD_ACC: begin
            psel    = 1'b1;
            penable = (state == S_RD_ACC);
            paddr   = ADDR_DATA;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: APB slave model with wait states, a round-robin
// reference model and an expected-access queue for the APB traffic.
module tb_spi_xfer_sched;
   localparam int N  = 4;
   localparam int TO = 16;
   localparam int TW = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req, req_cpol, req_cpha;
   logic [4*N-1:0] req_cs;
   logic [8*N-1:0] req_div, req_tx;
   logic [N-1:0]   gnt, done;
   logic [7:0]     rx_byte, paddr;
   logic           err, psel, penable, pwrite, pready, spi_irq;
   logic [31:0]    pwdata, prdata;

   int          checks = 0;
   int          failures = 0;
   int          model_rr = 0;
   int          slave_ws = 0;
   int          ws_left = 0;
   logic [7:0]  slave_rx = 8'h00;
   bit          rd_pending = 1'b0;
   logic [40:0] exp_q[$];
   logic [40:0] got, exp_e;
   logic [31:0] noise, s_wdata;
   logic [7:0]  s_addr;
   logic        s_write;

   always #5 clk = ~clk;

   spi_xfer_sched #(.N(N), .TIMEOUT(TO), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_cpol(req_cpol), .req_cpha(req_cpha),
      .req_cs(req_cs), .req_div(req_div), .req_tx(req_tx), .gnt(gnt), .done(done),
      .rx_byte(rx_byte), .err(err), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .spi_irq(spi_irq)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r);
      for (int k = 0; k < N; k++)
         if (r[(model_rr + k) % N]) return (model_rr + k) % N;
      return -1;
   endfunction

   task automatic rand_fields(input int i);
      req_cpol[i]        = 1'($urandom);
      req_cpha[i]        = 1'($urandom);
      req_cs[4*i +: 4]   = 4'($urandom);
      req_div[8*i +: 8]  = 8'($urandom);
      req_tx[8*i +: 8]   = 8'($urandom);
   endtask

   // APB slave: read data appears the cycle after the completing access.
   always @(negedge clk) begin
      noise  = $urandom;
      prdata = rd_pending ? {noise[31:8], slave_rx} : noise;
      rd_pending = 1'b0;
      if (!rst_n) begin
         ws_left = 0;
         pready  = 1'b0;
      end else if (psel && !penable) begin
         ws_left = slave_ws;
         s_addr  = paddr;
         s_wdata = pwdata;
         s_write = pwrite;
         pready  = 1'($urandom);
      end else if (psel && penable) begin
         chk("apb_addr_stable", 64'(paddr), 64'(s_addr));
         chk("apb_wdata_stable", 64'(pwdata), 64'(s_wdata));
         chk("apb_dir_stable", 64'(pwrite), 64'(s_write));
         if (ws_left > 0) begin
            pready = 1'b0;
            ws_left--;
         end else begin
            pready = 1'b1;
            got = {pwrite, paddr, pwrite ? pwdata : 32'h0};
            checks++;
            assert (exp_q.size() != 0) else begin
               failures++;
               $error("FAIL apb_unexpected observed=0x%0h expected=no access", got);
            end
            if (exp_q.size() != 0) begin
               exp_e = exp_q.pop_front();
               chk("apb_xfer", 64'(got), 64'(exp_e));
            end
            if (!pwrite) rd_pending = 1'b1;
         end
      end else begin
         pready = 1'($urandom);
      end
   end

   // One full transfer from grant to the cycle after done.
   // d >= TO means the SPI never interrupts; abort_at > 0 resets at that cycle.
   task automatic serve(input int ws, input int d, input logic [N-1:0] raise_mask,
                        input bit drop_mid, input bit drop_after, input int exp_wait,
                        input int abort_at, input logic [7:0] rx);
      int waited, win, w, e, k, done_c, last_wait;
      bit ok;
      logic [N-1:0] oh;
      logic [31:0] ctrl;
      slave_ws = ws;
      slave_rx = rx;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (gnt === '0 && waited < 40);
      ok = (gnt !== '0);
      checks++;
      assert (ok) else begin
         failures++;
         $error("FAIL grant_wait observed=0x%0h after %0d cycles expected=a grant", gnt, waited);
      end
      if (!ok) return;
      if (exp_wait > 0) chk("arb_latency", 64'(waited), 64'(exp_wait));
      win = pick(req);
      oh = '0;
      if (win >= 0) begin
         oh[win] = 1'b1;
         model_rr = (win + 1) % N;
      end
      chk("gnt_arb", 64'(gnt), 64'(oh));
      w = (win < 0) ? 0 : win;
      ctrl = 32'(req_cs[4*w +: 4]) * 16 + 32'(req_cpha[w]) * 4 + 32'(req_cpol[w]) * 2 + 1;
      exp_q.push_back({1'b1, 8'h0C, 24'h0, req_div[8*w +: 8]});
      exp_q.push_back({1'b1, 8'h08, 24'h0, req_tx[8*w +: 8]});
      exp_q.push_back({1'b1, 8'h00, ctrl});
      if (d < TO) exp_q.push_back({1'b0, 8'h08, 32'h0});
      e = 3 * (2 + ws) + 1;
      if (d < TO) begin
         k = e + d;
         done_c = k + 4 + ws;
         last_wait = k;
      end else begin
         k = -1;
         done_c = e + TO;
         last_wait = done_c - 1;
      end
      for (int c = 1; c <= done_c; c++) begin
         @(negedge clk);
         spi_irq = (c == k) || (c == 2);
         if (c == 2) rand_fields(w);
         if (c == 3) req = req | raise_mask;
         if (c == 4 && drop_mid) req[w] = 1'b0;
         if (c == abort_at) begin
            rst_n = 1'b0;
            spi_irq = 1'b0;
            #1;
            chk("rst_gnt", 64'(gnt), 64'h0);
            chk("rst_done", 64'(done), 64'h0);
            chk("rst_psel", 64'(psel), 64'h0);
            chk("rst_err", 64'(err), 64'h0);
            chk("rst_rx_byte", 64'(rx_byte), 64'h0);
            model_rr = 0;
            exp_q.delete();
            repeat (2) begin
               @(negedge clk);
               chk("rst_hold_done", 64'(done), 64'h0);
               chk("rst_hold_gnt", 64'(gnt), 64'h0);
            end
            rst_n = 1'b1;
            return;
         end
         chk("gnt_hold", 64'(gnt), 64'(oh));
         if (c >= e && c <= last_wait) chk("bus_idle_wait", 64'(psel), 64'h0);
         if (c < done_c) begin
            chk("done_early", 64'(done), 64'h0);
            chk("err_early", 64'(err), 64'h0);
         end else begin
            chk("done_pulse", 64'(done), 64'(oh));
            chk("err_flag", 64'(err), 64'(d >= TO));
            chk("rx_byte", 64'(rx_byte), 64'((d < TO) ? rx : 8'h00));
            chk("bus_idle_resp", 64'(psel), 64'h0);
         end
      end
      spi_irq = 1'b0;
      if (drop_after) req[w] = 1'b0;
      @(negedge clk);
      chk("gnt_fall", 64'(gnt), 64'h0);
      chk("done_once", 64'(done), 64'h0);
      chk("err_once", 64'(err), 64'h0);
      chk("rx_held", 64'(rx_byte), 64'((d < TO) ? rx : 8'h00));
      chk("sb_drained", 64'(exp_q.size()), 64'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req = '0;
      spi_irq = 1'b0;
      pready = 1'b0;
      prdata = '0;
      for (int i = 0; i < N; i++) rand_fields(i);
      repeat (3) @(negedge clk);
      chk("reset_gnt", 64'(gnt), 64'h0);
      chk("reset_done", 64'(done), 64'h0);
      chk("reset_err", 64'(err), 64'h0);
      chk("reset_psel", 64'(psel), 64'h0);
      chk("reset_penable", 64'(penable), 64'h0);
      chk("reset_pwrite", 64'(pwrite), 64'h0);
      chk("reset_paddr", 64'(paddr), 64'h0);
      chk("reset_pwdata", 64'(pwdata), 64'h0);
      chk("reset_rx_byte", 64'(rx_byte), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_req_gnt", 64'(gnt), 64'h0);

      // single requester, directed fields
      req_cpol[0] = 1'b0;
      req_cpha[0] = 1'b0;
      req_cs[3:0] = 4'd2;
      req_div[7:0] = 8'h03;
      req_tx[7:0] = 8'hA5;
      req = 4'b0001;
      serve(0, 5, '0, 0, 1, 1, 0, 8'h3C);

      // contention with every request held
      req = 4'b1111;
      repeat (5) serve(0, $urandom_range(0, 8), '0, 0, 0, 1, 0, 8'($urandom));

      // round-robin skip and a late-rising request
      req = 4'b0010;
      serve(0, 2, '0, 0, 1, 1, 0, 8'($urandom));
      req = 4'b0011;
      serve(0, 3, '0, 0, 0, 1, 0, 8'($urandom));
      serve(0, 1, 4'b1000, 0, 1, 1, 0, 8'($urandom));
      serve(0, 4, '0, 0, 1, 1, 0, 8'($urandom));
      serve(0, 0, '0, 0, 1, 1, 0, 8'($urandom));

      // three wait states in every access
      req = 4'b0110;
      serve(3, 2, '0, 0, 0, 1, 0, 8'($urandom));
      serve(3, 6, '0, 0, 1, 1, 0, 8'($urandom));

      // timeout, then a late irq while idle
      req = 4'b0100;
      serve(0, TO, '0, 0, 1, 1, 0, 8'($urandom));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         spi_irq = (i == 0);
         chk("late_irq_psel", 64'(psel), 64'h0);
         chk("late_irq_gnt", 64'(gnt), 64'h0);
         chk("late_irq_done", 64'(done), 64'h0);
      end
      spi_irq = 1'b0;

      // irq on the final timeout cycle wins
      req = 4'b0001;
      serve(1, TO - 1, '0, 0, 1, 1, 0, 8'($urandom));

      // randomized traffic
      for (int i = 0; i < 14; i++) begin
         req = 4'($urandom_range(1, 15));
         serve($urandom_range(0, 3), $urandom_range(0, TO + 3), 4'($urandom),
               1'($urandom), 1'($urandom), 1, 0, 8'($urandom));
      end

      // reset during WAIT_IRQ with requests left pending
      req = 4'b0100;
      serve(0, TO, 4'b1000, 0, 0, 1, 10, 8'($urandom));
      serve(0, 3, '0, 0, 1, 1, 0, 8'($urandom));
      serve(0, 5, '0, 0, 1, 1, 0, 8'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
